// File: rtl/mux_stream_pkg.sv
//------------------------------------------------------------------------------
// Module   : mux_stream_pkg
// Brief    : Shared types and constants for the mux_stream channel multiplexer.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package mux_stream_pkg;

  typedef enum logic {
    MODE_SEL = 1'b0,
    MODE_RR  = 1'b1
  } mode_e;

  localparam int DEF_WIDTH    = 4;
  localparam int DEF_CHANNELS = 8;
  localparam int XFER_CNT_W   = 16;

endpackage : mux_stream_pkg

`default_nettype wire

// File: rtl/mux_stream_if.sv
//------------------------------------------------------------------------------
// Module   : mux_stream_if
// Brief    : Channel-side and output-side handshake bundle for mux_stream.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface mux_stream_if
  import mux_stream_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int CHANNELS = DEF_CHANNELS
);

  localparam int SEL_W = $clog2(CHANNELS);

  logic [CHANNELS*WIDTH-1:0] in_data;
  logic [CHANNELS-1:0]       in_valid;
  logic [CHANNELS-1:0]       in_ready;
  logic [SEL_W:0]            sel;
  logic                      mode;
  logic [WIDTH-1:0]          out_data;
  logic [SEL_W-1:0]          out_chan;
  logic                      out_valid;
  logic                      out_ready;
  logic [XFER_CNT_W-1:0]     xfer_cnt;

  // Environment side: drives channels, select and downstream ready.
  modport master (
    output in_data, in_valid, sel, mode, out_ready,
    input  in_ready, out_data, out_chan, out_valid, xfer_cnt
  );

  // Multiplexer side.
  modport slave (
    input  in_data, in_valid, sel, mode, out_ready,
    output in_ready, out_data, out_chan, out_valid, xfer_cnt
  );

endinterface : mux_stream_if

`default_nettype wire

// File: rtl/mux_stream_rr_pick.sv
//------------------------------------------------------------------------------
// Module   : rr_pick
// Brief    : First set request at or after a pointer, wrapping at CHANNELS-1.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module rr_pick #(
  parameter int CHANNELS = 8
) (
  input  logic [CHANNELS-1:0]         i_req,
  input  logic [$clog2(CHANNELS)-1:0] i_ptr,
  output logic [$clog2(CHANNELS)-1:0] o_gnt_idx,
  output logic                        o_gnt_vld
);

  localparam int SEL_W = $clog2(CHANNELS);
  localparam logic [SEL_W:0] c_chan_num = (SEL_W+1)'(CHANNELS);

  logic [2*CHANNELS-1:0] w_req2;
  logic [CHANNELS-1:0]   w_rot;
  logic [SEL_W:0]        w_off;
  logic [SEL_W:0]        w_sum;
  logic [SEL_W:0]        w_wrapped;

  // Rotating a doubled copy puts the pointer channel at bit 0.
  assign w_req2 = {i_req, i_req};
  assign w_rot  = CHANNELS'(w_req2 >> i_ptr);

  always_comb begin
    w_off     = '0;
    o_gnt_vld = 1'b0;
    for (int j = CHANNELS - 1; j >= 0; j--) begin
      if (w_rot[j]) begin
        w_off     = (SEL_W+1)'(j);
        o_gnt_vld = 1'b1;
      end
    end
  end

  assign w_sum     = {1'b0, i_ptr} + w_off;
  assign w_wrapped = w_sum - c_chan_num;
  assign o_gnt_idx = (w_sum >= c_chan_num) ? w_wrapped[SEL_W-1:0] : w_sum[SEL_W-1:0];

endmodule : rr_pick

`default_nettype wire

// File: rtl/mux_stream.sv
//------------------------------------------------------------------------------
// Module   : mux_stream
// Brief    : N-to-1 valid/ready stream mux, explicit select or round-robin,
//            one registered output slot. Optional sticky err via
//            MUX_STREAM_ERR_EN.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mux_stream
  import mux_stream_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int CHANNELS = DEF_CHANNELS
) (
  input  logic clk,
  input  logic rst_n,
`ifdef MUX_STREAM_ERR_EN
  output logic err,
`endif
  mux_stream_if.slave bus
);

  localparam int SEL_W = $clog2(CHANNELS);

  mode_e                 w_mode;
  logic                  w_slot_free;
  logic                  w_sel_in_range;
  logic [SEL_W-1:0]      w_sel_idx;
  logic [SEL_W-1:0]      w_rr_idx;
  logic                  w_rr_vld;
  logic [SEL_W-1:0]      w_gnt_idx;
  logic                  w_gnt_vld;
  logic [CHANNELS-1:0]   w_in_ready;
  logic                  w_xfer;
  logic [WIDTH-1:0]      w_gnt_data;
  logic [SEL_W-1:0]      w_next_ptr;

  logic [WIDTH-1:0]      r_out_data;
  logic [SEL_W-1:0]      r_out_chan;
  logic                  r_out_valid;
  logic [SEL_W-1:0]      r_ptr;
  logic [XFER_CNT_W-1:0] r_xfer_cnt;

  assign w_mode         = mode_e'(bus.mode);
  assign w_slot_free    = !r_out_valid || bus.out_ready;
  assign w_sel_in_range = int'(bus.sel) < CHANNELS;
  assign w_sel_idx      = bus.sel[SEL_W-1:0];

  rr_pick #(
    .CHANNELS (CHANNELS)
  ) u_rr_pick (
    .i_req     (bus.in_valid),
    .i_ptr     (r_ptr),
    .o_gnt_idx (w_rr_idx),
    .o_gnt_vld (w_rr_vld)
  );

  // Ready is offered only to the channel the current mode points at.
  always_comb begin
    w_gnt_idx  = w_sel_idx;
    w_gnt_vld  = 1'b0;
    w_in_ready = '0;
    if (w_mode == MODE_RR) begin
      w_gnt_idx = w_rr_idx;
      w_gnt_vld = w_rr_vld;
      if (w_rr_vld) begin
        w_in_ready[w_rr_idx] = w_slot_free;
      end
    end else if (w_sel_in_range) begin
      w_gnt_vld              = bus.in_valid[w_sel_idx];
      w_in_ready[w_sel_idx]  = w_slot_free;
    end
    if (!rst_n) begin
      w_in_ready = '0;
    end
  end

  assign w_xfer     = w_gnt_vld && w_slot_free && rst_n;
  assign w_gnt_data = bus.in_data[int'(w_gnt_idx)*WIDTH +: WIDTH];
  assign w_next_ptr = (int'(w_gnt_idx) == CHANNELS - 1) ? '0 : w_gnt_idx + SEL_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_data  <= '0;
      r_out_chan  <= '0;
      r_out_valid <= 1'b0;
      r_ptr       <= '0;
      r_xfer_cnt  <= '0;
    end else if (w_xfer) begin
      r_out_data  <= w_gnt_data;
      r_out_chan  <= w_gnt_idx;
      r_out_valid <= 1'b1;
      r_xfer_cnt  <= r_xfer_cnt + XFER_CNT_W'(1);
      if (w_mode == MODE_RR) begin
        r_ptr <= w_next_ptr;
      end
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

`ifdef MUX_STREAM_ERR_EN
  logic r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_mode == MODE_SEL && !w_sel_in_range) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;
`endif

  assign bus.in_ready  = w_in_ready;
  assign bus.out_data  = r_out_data;
  assign bus.out_chan  = r_out_chan;
  assign bus.out_valid = r_out_valid;
  assign bus.xfer_cnt  = r_xfer_cnt;

endmodule : mux_stream

`default_nettype wire

// File: tb/tb_mux_stream.sv
//------------------------------------------------------------------------------
// Module   : tb_mux_stream
// Brief    : Directed self-checking bench for mux_stream (WIDTH=4, CHANNELS=8).
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_mux_stream;
  import mux_stream_pkg::*;

  localparam int WIDTH    = 4;
  localparam int CHANNELS = 8;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
`ifdef MUX_STREAM_ERR_EN
  logic err;
`endif

  mux_stream_if #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) bus ();

  mux_stream #(
    .WIDTH    (WIDTH),
    .CHANNELS (CHANNELS)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
`ifdef MUX_STREAM_ERR_EN
    .err   (err),
`endif
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.in_data   = 32'h7654_3210;
    bus.in_valid  = 8'h20;
    bus.sel       = 4'd5;
    bus.mode      = MODE_SEL;
    bus.out_ready = 1'b1;

    #7;
    chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_out_data",  32'(bus.out_data),  32'h0);
    chk("rst_out_chan",  32'(bus.out_chan),  32'h0);
    chk("rst_xfer_cnt",  32'(bus.xfer_cnt),  32'h0);
    chk("rst_in_ready",  32'(bus.in_ready),  32'h0);
`ifdef MUX_STREAM_ERR_EN
    chk("rst_err",       32'(err),           32'h0);
`endif

    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("sel5_in_ready", 32'(bus.in_ready), 32'h20);
    tick();
    chk("sel5_out_data",  32'(bus.out_data),  32'h5);
    chk("sel5_out_chan",  32'(bus.out_chan),  32'h5);
    chk("sel5_out_valid", 32'(bus.out_valid), 32'h1);
    chk("sel5_xfer_cnt",  32'(bus.xfer_cnt),  32'h1);

    // Round-robin over all channels, pointer still 0 after explicit transfer.
    bus.mode     = MODE_RR;
    bus.in_valid = 8'hFF;
    #1;
    chk("rr_in_ready", 32'(bus.in_ready), 32'h01);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("rr_out_chan", 32'(bus.out_chan), 32'(i % 8));
      chk("rr_out_data", 32'(bus.out_data), 32'(i % 8));
    end
    chk("rr_xfer_cnt", 32'(bus.xfer_cnt), 32'd11);

    // Sparse requests 1 and 4 with the pointer at 2.
    bus.in_valid = 8'h12;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rr12_out_chan", 32'(bus.out_chan), (i % 2 == 0) ? 32'd4 : 32'd1);
    end
    chk("rr12_xfer_cnt", 32'(bus.xfer_cnt), 32'd15);

    bus.out_ready = 1'b0;
    #1;
    chk("stall_in_ready0", 32'(bus.in_ready), 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_out_data",  32'(bus.out_data),  32'h1);
      chk("stall_out_chan",  32'(bus.out_chan),  32'h1);
      chk("stall_out_valid", 32'(bus.out_valid), 32'h1);
      chk("stall_in_ready",  32'(bus.in_ready),  32'h0);
      chk("stall_xfer_cnt",  32'(bus.xfer_cnt),  32'd15);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("resume_in_ready", 32'(bus.in_ready), 32'h10);
    tick();
    chk("resume_out_chan",  32'(bus.out_chan),  32'h4);
    chk("resume_out_valid", 32'(bus.out_valid), 32'h1);
    chk("resume_xfer_cnt",  32'(bus.xfer_cnt),  32'd16);

    bus.in_valid = 8'h00;
    tick();
    chk("drain_out_valid", 32'(bus.out_valid), 32'h0);
    chk("drain_out_data",  32'(bus.out_data),  32'h4);
    chk("drain_out_chan",  32'(bus.out_chan),  32'h4);

    // Out-of-range explicit select.
    bus.mode     = MODE_SEL;
    bus.sel      = 4'd9;
    bus.in_valid = 8'hFF;
    #1;
    chk("sel9_in_ready", 32'(bus.in_ready), 32'h0);
    tick();
    chk("sel9_out_valid", 32'(bus.out_valid), 32'h0);
    chk("sel9_xfer_cnt",  32'(bus.xfer_cnt),  32'd16);
`ifdef MUX_STREAM_ERR_EN
    chk("sel9_err", 32'(err), 32'h1);
`endif
    bus.sel = 4'd8;
    #1;
    chk("sel8_in_ready", 32'(bus.in_ready), 32'h0);
    bus.sel = 4'd2;
    #1;
    chk("sel2_in_ready", 32'(bus.in_ready), 32'h04);
    tick();
    chk("sel2_out_chan",  32'(bus.out_chan),  32'h2);
    chk("sel2_out_data",  32'(bus.out_data),  32'h2);
    chk("sel2_xfer_cnt",  32'(bus.xfer_cnt),  32'd17);
`ifdef MUX_STREAM_ERR_EN
    chk("sel2_err_sticky", 32'(err), 32'h1);
`endif

    // Selected channel without valid: ready offered, nothing moves.
    bus.sel      = 4'd3;
    bus.in_valid = 8'h04;
    #1;
    chk("novld_in_ready", 32'(bus.in_ready), 32'h08);
    tick();
    chk("novld_out_valid", 32'(bus.out_valid), 32'h0);
    chk("novld_xfer_cnt",  32'(bus.xfer_cnt),  32'd17);

    // Fill the slot with the pointer at 5, then stall and reset.
    bus.mode      = MODE_RR;
    bus.in_valid  = 8'hFF;
    bus.out_ready = 1'b0;
    #1;
    chk("fill_in_ready", 32'(bus.in_ready), 32'h20);
    tick();
    chk("fill_out_chan",  32'(bus.out_chan),  32'h5);
    chk("fill_out_valid", 32'(bus.out_valid), 32'h1);
    chk("fill_xfer_cnt",  32'(bus.xfer_cnt),  32'd18);
    #1;
    chk("fill_stall_in_ready", 32'(bus.in_ready), 32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("arst_out_data",  32'(bus.out_data),  32'h0);
    chk("arst_out_chan",  32'(bus.out_chan),  32'h0);
    chk("arst_xfer_cnt",  32'(bus.xfer_cnt),  32'h0);
    chk("arst_in_ready",  32'(bus.in_ready),  32'h0);
`ifdef MUX_STREAM_ERR_EN
    chk("arst_err",       32'(err),           32'h0);
`endif
    #1;
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", 32'(bus.in_ready), 32'h01);
    tick();
    chk("post_rst_out_chan",  32'(bus.out_chan),  32'h0);
    chk("post_rst_out_valid", 32'(bus.out_valid), 32'h1);
    chk("post_rst_xfer_cnt",  32'(bus.xfer_cnt),  32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_mux_stream

`default_nettype wire
